alu_rf_sequencer: RTL and testbench

- Multi-cycle controller that executes one register-to-register instruction at a time on the shared alu/register_file pair.
- Per instruction: reads rs1 and rs2 through the single-port register file (1-cycle registered read), drives the combinational alu, writes the result back to rd, and returns a response.
- Also supports a load-immediate instruction so that hosts and benches can initialise registers.
- Sits between an instruction source (valid/ready) and the alu/register_file instances.

---
 rtl/alu_rf_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_rf_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_rf_sequencer.sv
// Multi-cycle controller that runs one register-to-register instruction at a time
// on an external single-port register file (registered read) and combinational alu.
module alu_rf_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_wb,
  input  logic [DATA_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB, RESP} state_t;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(4'b0100);
  localparam logic [OP_W-1:0] OP_LDI = OP_W'(4'b1111);

  state_t state, state_nxt;

  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic              wb_q;
  logic [DATA_W-1:0] opa, res;
  logic              err;

  function automatic logic is_alu(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (state == RESP && out_ready) retired <= retired + CNT_W'(1);
    end
  end

  // NOTE: operand/result registers carry no reset; they are always written before
  // being observed, and out_result/out_err are gated to RESP.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (in_valid) begin
          op_q  <= in_op;
          rd_q  <= in_rd;
          rs1_q <= in_rs1;
          rs2_q <= in_rs2;
          wb_q  <= in_wb;
          res   <= in_imm;
          err   <= 1'b0;
        end
      end
      RD_B: opa <= rf_rdata;
      EXEC: begin
        res <= is_alu(op_q) ? alu_result : '0;
        err <= !is_alu(op_q);
      end
      default: ;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rf_we     = 1'b0;
    rf_addr   = '0;
    rf_wdata  = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_op == OP_LDI) ? WB : RD_A;
      end
      RD_A: begin
        rf_addr   = rs1_q;
        state_nxt = RD_B;
      end
      RD_B: begin
        rf_addr   = rs2_q;
        state_nxt = EXEC;
      end
      EXEC: begin
        alu_a     = opa;
        alu_b     = rf_rdata;
        alu_op    = op_q;
        state_nxt = WB;
      end
      WB: begin
        rf_addr   = rd_q;
        rf_wdata  = res;
        rf_we     = (op_q == OP_LDI) || (is_alu(op_q) && wb_q);
        state_nxt = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_result = (state == RESP) ? res : '0;
  assign out_err    = (state == RESP) && err;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Directed bench for alu_rf_sequencer with a behavioural register file and alu
// attached to its rf_*/alu_* ports.
module tb_alu_rf_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wb, out_valid, out_ready, out_err, rf_we;
  logic [3:0]  in_op, alu_op;
  logic [4:0]  in_rd, in_rs1, in_rs2, rf_addr;
  logic [31:0] in_imm, out_result, rf_wdata, alu_a, alu_b, alu_result;
  logic [31:0] rf_rdata;
  logic [15:0] retired;
  logic [31:0] mem [32];

  int checks   = 0;
  int failures = 0;
  int n_done   = 0;

  always #5 clk = ~clk;

  alu_rf_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_wb(in_wb), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_err(out_err),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .retired(retired)
  );

  // Single-port register file with registered read (read-before-write).
  always @(posedge clk) begin
    if (rf_we) mem[rf_addr] <= rf_wdata;
    rf_rdata <= mem[rf_addr];
  end

  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a ^ alu_b;
      default: alu_result = 32'h0;
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic        wb;
    logic [31:0] imm;
    logic [31:0] exp_res;
    logic        exp_err;
    logic        exp_we;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic wb, input logic [31:0] imm);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_wb = wb; in_imm = imm;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_done++;
    @(negedge clk);
    check("retired_after_hs", 32'(retired), 32'(n_done));
    check("out_valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  task automatic run(input vec_t v);
    int lat = 0;
    int we_cnt = 0;
    logic [4:0]  we_addr = '0;
    logic [31:0] we_data = '0;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    drive(v.op, v.rd, v.rs1, v.rs2, v.wb, v.imm);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) check("in_ready_busy", 32'(in_ready), 32'd0);
      if (rf_we) begin
        we_cnt++; we_addr = rf_addr; we_data = rf_wdata;
      end
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check("latency", 32'(lat), 32'(v.exp_lat));
    check("out_result", out_result, v.exp_res);
    check("out_err", 32'(out_err), 32'(v.exp_err));
    check("we_pulses", 32'(we_cnt), v.exp_we ? 32'd1 : 32'd0);
    if (v.exp_we) begin
      check("we_addr", 32'(we_addr), 32'(v.rd));
      check("we_data", we_data, v.exp_res);
    end
    if (lat != 0) handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int we_seen;
    //            op     rd  rs1 rs2 wb imm            res            err we  lat
    vecs[0]  = '{4'hF,  1,  0,  0, 0, 32'h0000_0005, 32'h0000_0005, 0, 1, 2};
    vecs[1]  = '{4'hF,  2,  0,  0, 0, 32'h0000_0003, 32'h0000_0003, 0, 1, 2};
    vecs[2]  = '{4'h0,  3,  1,  2, 1, 32'h0,         32'h0000_0008, 0, 1, 5};
    vecs[3]  = '{4'h3,  4,  3,  3, 1, 32'h0,         32'h0000_0008, 0, 1, 5};
    vecs[4]  = '{4'h1,  5,  2,  1, 1, 32'h0,         32'hFFFF_FFFE, 0, 1, 5};
    vecs[5]  = '{4'h4,  6,  1,  1, 1, 32'h0,         32'h0000_0000, 0, 1, 5};
    vecs[6]  = '{4'h2,  7,  1,  2, 0, 32'h0,         32'h0000_0001, 0, 0, 5};
    vecs[7]  = '{4'h7,  8,  1,  2, 1, 32'h0,         32'h0000_0000, 1, 0, 5};
    vecs[8]  = '{4'hF,  9,  0,  0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1, 2};
    vecs[9]  = '{4'h0, 10,  9,  9, 1, 32'h0,         32'hBD5B_7DDE, 0, 1, 5};
    vecs[10] = '{4'h3, 11,  7,  8, 1, 32'h0,         32'h0000_0000, 0, 1, 5};

    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(4'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);

    for (int i = 0; i < 11; i++) run(vecs[i]);

    // Stalled response: hold out_ready low while another instruction is offered.
    @(negedge clk);
    drive(4'hF, 5'd12, 5'd0, 5'd0, 1'b0, 32'h1234_5678);
    @(posedge clk); #1;
    drive(4'hF, 5'd13, 5'd0, 5'd0, 1'b0, 32'h0000_0BAD);
    @(negedge clk);
    @(negedge clk);
    we_seen = 0;
    for (int c = 0; c < 10; c++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_result", out_result, 32'h1234_5678);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      if (rf_we) we_seen++;
      @(negedge clk);
    end
    check("hold_no_we", 32'(we_seen), 32'd0);
    check("hold_retired", 32'(retired), 32'(n_done));
    in_valid = 1'b0;
    handshake();
    check("hold_in_ready_after", 32'(in_ready), 32'd1);
    check("ignored_instr_no_write", mem[13], 32'h0);

    // Reset during EXEC of add r7, r1, r2.
    @(negedge clk);
    drive(4'h0, 5'd7, 5'd1, 5'd2, 1'b1, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("exec_alu_a", alu_a, 32'h5);
    check("exec_alu_b", alu_b, 32'h3);
    check("exec_alu_op", 32'(alu_op), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_retired", 32'(retired), 32'd0);
    check("mid_rst_out_result", out_result, 32'd0);
    we_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (rf_we) we_seen++;
      @(negedge clk);
    end
    check("mid_rst_no_we", 32'(we_seen), 32'd0);
    check("mid_rst_r7_intact", mem[7], 32'h0);
    n_done = 0;
    run('{4'hF, 5'd14, 5'd0, 5'd0, 1'b0, 32'h0000_0077, 32'h0000_0077, 1'b0, 1'b1, 2});
    check("r14_written", mem[14], 32'h0000_0077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
